// File: rtl/histogram_pkg.sv
// Shared types and sizing for the histogram dataflow (map stages, ping-pong channel, reduce stage).
package histogram_pkg;

    localparam int HIST_DATA_W = 32;
    localparam int HIST_BINS   = 256;
    localparam int HIST_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } hist_state_e;

endpackage

// File: rtl/histogram_reduce_stage_if.sv
// ap_ctrl_chain handshake plus the two channel-tail read ports and the result write port.
interface histogram_reduce_stage_if #(
    parameter int DATA_W = histogram_pkg::HIST_DATA_W,
    parameter int ADDR_W = histogram_pkg::HIST_ADDR_W
);

    logic              ap_start;
    logic              ap_done;
    logic              ap_continue;
    logic              ap_idle;
    logic              ap_ready;

    logic [ADDR_W-1:0] hist1_address0;
    logic              hist1_ce0;
    logic [DATA_W-1:0] hist1_q0;
    logic [ADDR_W-1:0] hist2_address0;
    logic              hist2_ce0;
    logic [DATA_W-1:0] hist2_q0;

    logic [ADDR_W-1:0] output_r_address0;
    logic              output_r_ce0;
    logic              output_r_we0;
    logic [DATA_W-1:0] output_r_d0;

    // master is the reduce stage itself; slave is the surrounding channel/memory side
    modport master (
        input  ap_start, ap_continue, hist1_q0, hist2_q0,
        output ap_done, ap_idle, ap_ready,
        output hist1_address0, hist1_ce0, hist2_address0, hist2_ce0,
        output output_r_address0, output_r_ce0, output_r_we0, output_r_d0
    );

    modport slave (
        output ap_start, ap_continue, hist1_q0, hist2_q0,
        input  ap_done, ap_idle, ap_ready,
        input  hist1_address0, hist1_ce0, hist2_address0, hist2_ce0,
        input  output_r_address0, output_r_ce0, output_r_we0, output_r_d0
    );

endinterface

// File: rtl/histogram_bin_adder.sv
// Per-bin combinational adder; HISTOGRAM_REDUCE_SAT_EN selects saturating instead of wrapping add.
module histogram_bin_adder #(
    parameter int DATA_W = histogram_pkg::HIST_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

`ifdef HISTOGRAM_REDUCE_SAT_EN
    logic [DATA_W:0] wide_sum;

    assign wide_sum = {1'b0, a} + {1'b0, b};
    // a carry-out means the true count no longer fits, so clamp to all-ones
    assign sum      = wide_sum[DATA_W] ? '1 : wide_sum[DATA_W-1:0];
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/histogram_reduce_stage.sv
// Final reduce stage: streams every bin of both channel tails once and writes hist1[i] + hist2[i].
// Build option HISTOGRAM_REDUCE_SAT_EN makes the per-bin add saturate instead of wrap.
module histogram_reduce_stage #(
    parameter int DATA_W = histogram_pkg::HIST_DATA_W,
    parameter int BINS   = histogram_pkg::HIST_BINS,
    parameter int ADDR_W = histogram_pkg::HIST_ADDR_W
) (
    input logic                      ap_clk,
    input logic                      ap_rst_n,
    histogram_reduce_stage_if.master bus
);

    import histogram_pkg::*;

    // counter carries one extra bit so the terminal count never aliases with address 0
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(BINS - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    hist_state_e       state;
    hist_state_e       state_next;
    logic [ADDR_W:0]   rd_cnt;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              issue_rd;
    logic [DATA_W-1:0] bin_sum;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // read counter plus the valid/address pair that lines up with q0 one cycle later
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
        end else begin
            rd_valid <= issue_rd;
            rd_addr  <= rd_cnt[ADDR_W-1:0];
            if (state == IDLE) begin
                rd_cnt <= '0;
            end else if (issue_rd) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_next  = state;
        bus.ap_idle  = 1'b0;
        bus.ap_done  = 1'b0;
        bus.ap_ready = 1'b0;
        issue_rd     = 1'b0;
        case (state)
            IDLE: begin
                bus.ap_idle = 1'b1;
                if (bus.ap_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                issue_rd = 1'b1;
                if (rd_cnt == LAST_CNT) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // last bin is being written now, so the channel tails can be handed back
                bus.ap_ready = 1'b1;
                state_next   = DONE;
            end
            DONE: begin
                bus.ap_done = 1'b1;
                if (bus.ap_continue) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    histogram_bin_adder #(
        .DATA_W (DATA_W)
    ) u_bin_adder (
        .a   (bus.hist1_q0),
        .b   (bus.hist2_q0),
        .sum (bin_sum)
    );

    assign bus.hist1_ce0         = issue_rd;
    assign bus.hist2_ce0         = issue_rd;
    assign bus.hist1_address0    = issue_rd ? rd_cnt[ADDR_W-1:0] : '0;
    assign bus.hist2_address0    = issue_rd ? rd_cnt[ADDR_W-1:0] : '0;

    assign bus.output_r_ce0      = rd_valid;
    assign bus.output_r_we0      = rd_valid;
    assign bus.output_r_address0 = rd_valid ? rd_addr : '0;
    assign bus.output_r_d0       = rd_valid ? bin_sum : '0;

endmodule
